// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - 1 Hz tick generator and two-button time-set controller for a 12-hour BCD clock
//
// Purpose:
//   Free-running prescaler producing the per-second counter enable, plus a
//   RUN / SET_HH / SET_MM / COMMIT state machine that edits hour, minute and
//   PM in shadow registers and commits them with a one-cycle load strobe.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   btn_mode, btn_inc   debounced button levels (rising edges are used)
//   cur_hh/cur_mm/cur_pm  live counter time, captured on entry to set mode
//   tick                one-cycle enable per second, RUN only
//   load                one-cycle commit strobe (COMMIT state)
//   ld_hh/ld_mm/ld_pm   edited time presented with load
//   mode                0=RUN, 1=SET_HH, 2=SET_MM
//   blink               display blink phase, 0 outside set states
//
// Configuration macro: AUTO_REPEAT_EN (held increment button auto-repeats).

module clock_set_ctrl #(
    parameter int TICK_DIV  = 10000000,
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic       cur_pm,
    output logic       tick,
    output logic       load,
    output logic [7:0] ld_hh,
    output logic [7:0] ld_mm,
    output logic       ld_pm,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  DIV_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  HALF_LAST = PW'(TICK_DIV / 2 - 1);
    localparam logic [7:0]     TO_LAST   = 8'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] pcnt;
    logic [7:0]    to_cnt;
    logic [7:0]    to_cnt_n;
    logic          mode_q;
    logic          inc_q;
    logic          mode_e;
    logic          inc_e;
    logic          inc_go;
    logic          sec;
    logic          half;
    logic          in_set;
    logic          blink_n;
    logic [7:0]    hh_n;
    logic [7:0]    mm_n;
    logic          pm_n;
    logic [7:0]    hh_inc;
    logic [7:0]    mm_inc;
    logic          pm_inc;

    assign sec    = (pcnt == DIV_LAST);
    assign half   = sec || (pcnt == HALF_LAST);
    assign mode_e = btn_mode & ~mode_q;
    assign inc_e  = btn_inc & ~inc_q;
    assign in_set = (state == SET_HH) || (state == SET_MM);

`ifdef AUTO_REPEAT_EN
    // Repeat arms once the button has been held a full second since its
    // rising edge, then fires on every prescaler half until release.
    logic [PW-1:0] rep_cnt;
    logic          rep_armed;
    logic          rep_fire;

    assign rep_fire = rep_armed & half & btn_inc;
    assign inc_go   = inc_e | rep_fire;

    always_ff @(posedge clk) begin
        if (reset || !btn_inc || !in_set || (state_n != state) || inc_e) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (!rep_armed) begin
            if (rep_cnt == DIV_LAST) begin
                rep_armed <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + PW'(1);
            end
        end
    end
`else
    assign inc_go = inc_e;
`endif

    // 12-hour BCD hour step; PM flips when passing 11 -> 12.
    always_comb begin
        hh_inc = ld_hh + 8'd1;
        pm_inc = ld_pm;
        if (ld_hh == 8'h12) begin
            hh_inc = 8'h01;
        end else if (ld_hh == 8'h09) begin
            hh_inc = 8'h10;
        end else if (ld_hh == 8'h11) begin
            hh_inc = 8'h12;
            pm_inc = ~ld_pm;
        end
    end

    // BCD minute step 00..59, no carry into hours.
    always_comb begin
        mm_inc = ld_mm + 8'd1;
        if (ld_mm[3:0] == 4'd9) begin
            if (ld_mm[7:4] == 4'd5) begin
                mm_inc = 8'h00;
            end else begin
                mm_inc = {ld_mm[7:4] + 4'd1, 4'd0};
            end
        end
    end

    always_comb begin
        state_n  = state;
        to_cnt_n = to_cnt;
        hh_n     = ld_hh;
        mm_n     = ld_mm;
        pm_n     = ld_pm;
        load     = 1'b0;
        case (state)
            RUN: begin
                if (mode_e) begin
                    hh_n     = cur_hh;
                    mm_n     = cur_mm;
                    pm_n     = cur_pm;
                    to_cnt_n = 8'd0;
                    state_n  = SET_HH;
                end
            end
            SET_HH, SET_MM: begin
                // Mode edge takes priority; a coincident increment is dropped.
                if (mode_e) begin
                    to_cnt_n = 8'd0;
                    state_n  = (state == SET_HH) ? SET_MM : COMMIT;
                end else if (inc_go) begin
                    to_cnt_n = 8'd0;
                    if (state == SET_HH) begin
                        hh_n = hh_inc;
                        pm_n = pm_inc;
                    end else begin
                        mm_n = mm_inc;
                    end
                end else if (sec) begin
                    if (to_cnt == TO_LAST) begin
                        to_cnt_n = 8'd0;
                        state_n  = RUN;
                    end else begin
                        to_cnt_n = to_cnt + 8'd1;
                    end
                end
            end
            COMMIT: begin
                load    = 1'b1;
                state_n = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    // Blink runs only while staying within the set states; anything else
    // (entry to RUN, COMMIT) forces it low.
    always_comb begin
        blink_n = 1'b0;
        if (in_set && ((state_n == SET_HH) || (state_n == SET_MM))) begin
            blink_n = blink ^ half;
        end
    end

    always_comb begin
        case (state)
            SET_HH:  mode = 2'd1;
            SET_MM:  mode = 2'd2;
            default: mode = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            pcnt   <= '0;
            to_cnt <= 8'd0;
            mode_q <= 1'b0;
            inc_q  <= 1'b0;
            tick   <= 1'b0;
            ld_hh  <= 8'h12;
            ld_mm  <= 8'h00;
            ld_pm  <= 1'b0;
            blink  <= 1'b0;
        end else begin
            state  <= state_n;
            // Commit restarts the second so the counter gets a full second
            // after being loaded.
            pcnt   <= ((state == COMMIT) || sec) ? '0 : pcnt + PW'(1);
            to_cnt <= to_cnt_n;
            mode_q <= btn_mode;
            inc_q  <= btn_inc;
            tick   <= sec && (state == RUN);
            ld_hh  <= hh_n;
            ld_mm  <= mm_n;
            ld_pm  <= pm_n;
            blink  <= blink_n;
        end
    end

endmodule
